// File: rtl/cu_pkg.sv
// ============================================================================
// Module      : cu_pkg
// Description : Control-word type, source/condition enums and opcode constants
//               shared by the decode queue and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

    typedef enum logic [2:0] {
        WR_NONE = 3'd0,
        WR_ALU  = 3'd1,
        WR_REG  = 3'd2,
        WR_MEM  = 3'd3,
        WR_IMM  = 3'd4
    } write_register_src_t;

    typedef enum logic [1:0] {
        WM_NONE = 2'd0,
        WM_REG  = 2'd1
    } write_memory_src_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_SEQ  = 2'd1,
        JMP_REL  = 2'd2,
        JMP_ABS  = 2'd3
    } jump_src_t;

    typedef enum logic [2:0] {
        JC_ALWAYS = 3'd0,
        JC_C1     = 3'd1,
        JC_C2     = 3'd2,
        JC_C3     = 3'd3,
        JC_C4     = 3'd4,
        JC_C5     = 3'd5,
        JC_C6     = 3'd6,
        JC_C7     = 3'd7
    } jump_condition_t;

    typedef struct packed {
        logic                halt;
        logic                rsrc1_special;
        logic                rdest_special;
        logic                alu_b_use_immediate;
        write_register_src_t wr_src;
        write_memory_src_t   wm_src;
        jump_src_t           jmp_src;
        jump_condition_t     jump_cond;
    } control_signal_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HLT  = 8'h03;
    localparam logic [7:0] OP_JMPR = 8'h20;
    localparam logic [7:0] OP_JMPA = 8'h40;
    localparam logic [7:0] OP_CPY  = 8'h90;
    localparam logic [7:0] OP_CPYI = 8'hB0;
    localparam logic [7:0] OP_STOA = 8'hD0;
    localparam logic [7:0] OP_LODA = 8'hD1;

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
// Module      : cu_decode
// Description : Purely combinational opcode -> control word / ALU op / illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_decode
    import cu_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int ALU_OP_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output control_signal_t     ctrl_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                illegal_o
);

    logic w_hi_bits;

    generate
        if (OPCODE_W > 8) begin : g_wide
            assign w_hi_bits = |opcode_i[OPCODE_W-1:8];
        end else begin : g_narrow
            assign w_hi_bits = 1'b0;
        end
    endgenerate

    always_comb begin
        ctrl_o    = '0;
        alu_op_o  = '0;
        illegal_o = 1'b0;
        case (opcode_i[7:0])
            OP_NOP:  ;
            OP_HLT:  ctrl_o.halt    = 1'b1;
            OP_JMPR: ctrl_o.jmp_src = JMP_REL;
            OP_JMPA: ctrl_o.jmp_src = JMP_ABS;
            8'h80, 8'h81, 8'h82, 8'h84, 8'h86, 8'h87, 8'h88, 8'h89, 8'h8A: begin
                ctrl_o.wr_src = WR_ALU;
                alu_op_o      = ALU_OP_W'(opcode_i[3:0]);
            end
            OP_CPY:  ctrl_o.wr_src = WR_REG;
            8'hA0, 8'hA1: begin
                ctrl_o.alu_b_use_immediate = 1'b1;
                ctrl_o.wr_src              = WR_ALU;
                alu_op_o                   = ALU_OP_W'(opcode_i[3:0]);
            end
            OP_CPYI: ctrl_o.wr_src = WR_IMM;
            8'hB2, 8'hB3, 8'hB4, 8'hB5: begin
                ctrl_o.jmp_src   = JMP_REL;
                ctrl_o.jump_cond = jump_condition_t'(opcode_i[2:0]);
            end
            OP_STOA: ctrl_o.wm_src = WM_REG;
            OP_LODA: ctrl_o.wr_src = WR_MEM;
            default: illegal_o = 1'b1;
        endcase
        // Any set bit above the base 8-bit opcode space overrides the table.
        if (illegal_o || w_hi_bits) begin
            ctrl_o      = '0;
            ctrl_o.halt = 1'b1;
            alu_op_o    = '0;
            illegal_o   = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cu_decode_queue.sv
// ============================================================================
// Module      : cu_decode_queue
// Description : Valid/ready opcode decoder feeding a DEPTH-entry control FIFO
//               with a latched halt. Optional trap: CU_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_decode_queue
    import cu_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4,
    parameter int ALU_OP_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPCODE_W-1:0]        in_opcode,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [13:0]                out_ctrl,
    output logic [ALU_OP_W-1:0]        out_alu_op,
    output logic [ADDR_W-1:0]          out_addr,
    input  logic                       flush,
    input  logic                       resume,
    output logic                       halted,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic                       illegal,
    output logic [OPCODE_W-1:0]        illegal_opcode,
`endif
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    control_signal_t     w_dec_ctrl;
    control_signal_t     w_entry;
    logic [ALU_OP_W-1:0] w_dec_alu;
    logic                w_dec_illegal;

    cu_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .opcode_i  (in_opcode),
        .ctrl_o    (w_dec_ctrl),
        .alu_op_o  (w_dec_alu),
        .illegal_o (w_dec_illegal)
    );

    always_comb begin
        w_entry      = w_dec_ctrl;
        w_entry.halt = w_dec_ctrl.halt | w_dec_illegal;
    end

    control_signal_t     ctrl_mem [DEPTH];
    logic [ALU_OP_W-1:0] alu_mem  [DEPTH];
    logic [ADDR_W-1:0]   addr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             halted_q, halted_d;

    logic w_full, w_empty, w_push, w_pop;

    assign w_full    = (level_q == LVL_W'(DEPTH));
    assign w_empty   = (level_q == '0);
    assign in_ready  = !w_full && !halted_q && !flush;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_ctrl   = w_empty ? 14'd0 : ctrl_mem[rd_ptr_q];
    assign out_alu_op = w_empty ? '0 : alu_mem[rd_ptr_q];
    assign out_addr   = w_empty ? '0 : addr_mem[rd_ptr_q];
    assign halted     = halted_q;
    assign level      = level_q;

    // DEPTH is a power of two, so plain increments wrap the pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // A halting accept wins over a coincident resume.
    always_comb begin
        halted_d = halted_q;
        if (resume)                    halted_d = 1'b0;
        if (w_push && w_entry.halt)    halted_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            ctrl_mem[wr_ptr_q] <= w_entry;
            alu_mem[wr_ptr_q]  <= w_dec_alu;
            addr_mem[wr_ptr_q] <= in_addr;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic                illegal_q, illegal_d;
    logic [OPCODE_W-1:0] illegal_opcode_q, illegal_opcode_d;

    always_comb begin
        illegal_d        = illegal_q;
        illegal_opcode_d = illegal_opcode_q;
        if (resume) begin
            illegal_d        = 1'b0;
            illegal_opcode_d = '0;
        end
        if (w_push && w_dec_illegal && (!illegal_q || resume)) begin
            illegal_d        = 1'b1;
            illegal_opcode_d = in_opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q        <= 1'b0;
            illegal_opcode_q <= '0;
        end else begin
            illegal_q        <= illegal_d;
            illegal_opcode_q <= illegal_opcode_d;
        end
    end

    assign illegal        = illegal_q;
    assign illegal_opcode = illegal_opcode_q;
`endif

endmodule

`default_nettype wire
